thermo_readback: RTL

- Capture side of the thermometer drive path: snapshots a 256-bit thermometer word (e.g. the registered drive word ahead of the non-overlap stage) and decodes it to a binary level.
- Checks the word for bubbles, i.e. any 1 above a 0.
- Streams the snapshot back out as 8-bit bytes over a valid/ready handshake, in the byte order the 8-bit shift-in loader expects, so a streamed word reloads into the loader unchanged.

---
 rtl/thermo_readback.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/thermo_readback.sv
// Snapshot a thermometer drive word, decode its level chunk by chunk while checking for
// bubbles, then stream the snapshot back out MSB-byte first over valid/ready.
module thermo_readback #(
    parameter int WIDTH = 256,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] thermo_in,
    input  logic             capture,
    output logic             busy,
    output logic [8:0]       level,
    output logic             level_valid,
    output logic             bubble_err,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int NBYTES = WIDTH / 8;
    localparam int IDX_W  = $clog2(NCHUNK + 1);
    localparam int SEL_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, DECODE, STREAM} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   snap_reg, snap_next;
    logic [IDX_W-1:0]   chunk_idx_reg, chunk_idx_next;
    logic [BYTE_W-1:0]  byte_cnt_reg, byte_cnt_next;
    logic [8:0]         level_reg, level_next;
    logic               bubble_reg, bubble_next;
    logic               level_valid_reg, level_valid_next;
    logic               prev_top_reg, prev_top_next;
    logic               done_reg, done_next;

    logic [CHUNK-1:0]   chunk_arr [NCHUNK];
    logic [CHUNK-1:0]   chunk_cur;
    logic [SEL_W-1:0]   chunk_sel;
    logic [8:0]         chunk_pop;
    logic               chunk_bubble;

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign chunk_arr[gi] = snap_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // DECODE spends one extra cycle at index NCHUNK to publish the result; select chunk 0 then.
    assign chunk_sel = (chunk_idx_reg < IDX_W'(NCHUNK)) ? chunk_idx_reg[SEL_W-1:0] : '0;
    assign chunk_cur = chunk_arr[chunk_sel];

    always_comb begin
        chunk_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_pop = chunk_pop + 9'(chunk_cur[i]);
        end
    end

    // A 0 directly below a 1, inside the chunk or across the boundary with the previous chunk.
    assign chunk_bubble = (|(~chunk_cur[CHUNK-2:0] & chunk_cur[CHUNK-1:1]))
                        | (chunk_cur[0] & ~prev_top_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            snap_reg        <= '0;
            chunk_idx_reg   <= '0;
            byte_cnt_reg    <= '0;
            level_reg       <= '0;
            bubble_reg      <= 1'b0;
            level_valid_reg <= 1'b0;
            prev_top_reg    <= 1'b1;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            snap_reg        <= snap_next;
            chunk_idx_reg   <= chunk_idx_next;
            byte_cnt_reg    <= byte_cnt_next;
            level_reg       <= level_next;
            bubble_reg      <= bubble_next;
            level_valid_reg <= level_valid_next;
            prev_top_reg    <= prev_top_next;
            done_reg        <= done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        snap_next        = snap_reg;
        chunk_idx_next   = chunk_idx_reg;
        byte_cnt_next    = byte_cnt_reg;
        level_next       = level_reg;
        bubble_next      = bubble_reg;
        level_valid_next = level_valid_reg;
        prev_top_next    = prev_top_reg;
        done_next        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (capture) begin
                    snap_next        = thermo_in;
                    level_next       = '0;
                    bubble_next      = 1'b0;
                    level_valid_next = 1'b0;
                    chunk_idx_next   = '0;
                    prev_top_next    = 1'b1;
                    state_next       = DECODE;
                end
            end
            DECODE: begin
                if (chunk_idx_reg == IDX_W'(NCHUNK)) begin
                    level_valid_next = 1'b1;
                    byte_cnt_next    = '0;
                    state_next       = STREAM;
                end else begin
                    level_next     = level_reg + chunk_pop;
                    bubble_next    = bubble_reg | chunk_bubble;
                    prev_top_next  = chunk_cur[CHUNK-1];
                    chunk_idx_next = chunk_idx_reg + IDX_W'(1);
                end
            end
            STREAM: begin
                if (out_ready) begin
                    snap_next     = {snap_reg[WIDTH-9:0], 8'h00};
                    byte_cnt_next = byte_cnt_reg + BYTE_W'(1);
                    if (byte_cnt_reg == BYTE_W'(NBYTES - 1)) begin
                        byte_cnt_next = '0;
                        done_next     = 1'b1;
                        state_next    = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy        = (state_reg != IDLE);
    assign out_valid   = (state_reg == STREAM);
    assign out_data    = out_valid ? snap_reg[WIDTH-1 -: 8] : 8'h00;
    assign level       = level_reg;
    assign level_valid = level_valid_reg;
    assign bubble_err  = bubble_reg;
    assign done        = done_reg;

endmodule
